pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry elastic pipeline register (main slot + skid slot).
// Defining PIPE_STALL_CNT_EN adds the saturating stall_cnt output.
module pipe_stage_reg #(
    parameter int DATA_W = 133,
    parameter int CTRL_W = 12
) (
    input  logic              clkIn,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_BAD   = 2'b10,
        ST_TWO   = 2'b11
    } state_t;

    logic              main_valid_r;
    logic              skid_valid_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;

    state_t            state_s;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              main_valid_nx_s;
    logic              skid_valid_nx_s;
    logic              main_load_s;
    logic              main_from_skid_s;
    logic              skid_load_s;

    assign in_xfer_s  = in_valid & ~skid_valid_r;
    assign out_xfer_s = main_valid_r & out_ready;

    // Decode the two valid bits into the occupancy state.
    always_comb begin
        state_s = ST_EMPTY;
        case ({skid_valid_r, main_valid_r})
            2'b00:   state_s = ST_EMPTY;
            2'b01:   state_s = ST_ONE;
            2'b11:   state_s = ST_TWO;
            default: state_s = ST_BAD;
        endcase
    end

    // Next occupancy and slot write enables; flush overrides everything.
    always_comb begin
        main_valid_nx_s  = main_valid_r;
        skid_valid_nx_s  = skid_valid_r;
        main_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush) begin
            main_valid_nx_s = 1'b0;
            skid_valid_nx_s = 1'b0;
        end else begin
            case (state_s)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        main_valid_nx_s = 1'b1;
                        main_load_s     = 1'b1;
                    end else begin
                        main_valid_nx_s = 1'b0;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_load_s = 1'b1;
                    end else if (in_xfer_s) begin
                        skid_valid_nx_s = 1'b1;
                        skid_load_s     = 1'b1;
                    end else if (out_xfer_s) begin
                        main_valid_nx_s = 1'b0;
                    end else begin
                        main_valid_nx_s = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (out_xfer_s) begin
                        skid_valid_nx_s  = 1'b0;
                        main_from_skid_s = 1'b1;
                    end else begin
                        skid_valid_nx_s = 1'b1;
                    end
                end
                default: begin
                    main_valid_nx_s = 1'b0;
                    skid_valid_nx_s = 1'b0;
                end
            endcase
        end
    end

    // Valid bits and slot payloads; payloads only change on their slot's write.
    always_ff @(posedge clkIn) begin
        if (!resetn) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            main_data_r  <= {DATA_W{1'b0}};
            main_ctrl_r  <= {CTRL_W{1'b0}};
            skid_data_r  <= {DATA_W{1'b0}};
            skid_ctrl_r  <= {CTRL_W{1'b0}};
        end else begin
            main_valid_r <= main_valid_nx_s;
            skid_valid_r <= skid_valid_nx_s;
            if (main_load_s) begin
                main_data_r <= in_data;
                main_ctrl_r <= in_ctrl;
            end else if (main_from_skid_s) begin
                main_data_r <= skid_data_r;
                main_ctrl_r <= skid_ctrl_r;
            end
            if (skid_load_s) begin
                skid_data_r <= in_data;
                skid_ctrl_r <= in_ctrl;
            end
        end
    end

    assign in_ready  = ~skid_valid_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;
    // Bubbles must never present live control bits downstream.
    assign out_ctrl  = main_ctrl_r & {CTRL_W{main_valid_r}};

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where a live beat is held back.
    always_ff @(posedge clkIn) begin
        if (!resetn) begin
            stall_cnt_r <= 16'd0;
        end else if (main_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a capacity-2 FIFO queue model predicts
// handshakes and the head beat; a monitor compares the DUT against it each cycle.
module tb_pipe_stage_reg;

    localparam int DW = 133;
    localparam int CW = 12;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clkIn;
    logic          resetn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   stall_m;
`endif

    beat_t exp_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    bit    mon_en = 1'b0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clkIn     (clkIn),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of at most two beats.
    always @(posedge clkIn) begin
        int  occ;
        bit  acc_in;
        bit  acc_out;
        occ = exp_q.size();
        if (!resetn) begin
            exp_q.delete();
            mon_en = 1'b1;
`ifdef PIPE_STALL_CNT_EN
            stall_m = 16'd0;
`endif
        end else begin
`ifdef PIPE_STALL_CNT_EN
            if (occ > 0 && !out_ready && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
`endif
            if (flush) begin
                exp_q.delete();
            end else begin
                acc_out = (occ > 0) && out_ready;
                acc_in  = in_valid && (occ < 2);
                if (acc_out) void'(exp_q.pop_front());
                if (acc_in) exp_q.push_back('{c: in_ctrl, d: in_data});
            end
        end
    end

    // Monitor: compare DUT outputs against the model just after each edge.
    always @(posedge clkIn) begin
        #1;
        if (mon_en) begin
            chk("in_ready", 160'(in_ready), 160'(exp_q.size() < 2));
            chk("out_valid", 160'(out_valid), 160'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("out_data", 160'(out_data), 160'(exp_q[0].d));
                chk("out_ctrl", 160'(out_ctrl), 160'(exp_q[0].c));
            end else begin
                chk("out_ctrl_bubble", 160'(out_ctrl), 160'(0));
            end
`ifdef PIPE_STALL_CNT_EN
            chk("stall_cnt", 160'(stall_cnt), 160'(stall_m));
`endif
        end
    end

    task automatic step(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input bit ordy, input bit fl, input bit rn);
        @(negedge clkIn);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        resetn    = rn;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = {DW{1'b0}}; in_ctrl = {CW{1'b0}};
        step(1'b1, 133'h5A, 12'hFFF, 1'b1, 1'b1, 1'b0);
        step(1'b0, 133'h0, 12'h000, 1'b0, 1'b0, 1'b0);
        // Streaming 1,2,3,4.
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b1);
        step(1'b0, 133'h0, 12'h000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 133'h0, 12'h000, 1'b1, 1'b0, 1'b1);
        // Stall fill A,B then a refused C, then drain.
        step(1'b1, 133'hA, 12'h00A, 1'b0, 1'b0, 1'b1);
        step(1'b1, 133'hB, 12'h00B, 1'b0, 1'b0, 1'b1);
        step(1'b1, 133'hC, 12'h00C, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 133'h0, 12'h000, 1'b1, 1'b0, 1'b1);
        // Simultaneous in/out while ONE.
        step(1'b1, 133'hA1, 12'h0A1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 133'hC1, 12'h0C1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 133'h0, 12'h000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 133'h0, 12'h000, 1'b1, 1'b0, 1'b1);
        // Flush from TWO with an incoming beat D.
        step(1'b1, 133'h11, 12'h011, 1'b0, 1'b0, 1'b1);
        step(1'b1, 133'h22, 12'h022, 1'b0, 1'b0, 1'b1);
        step(1'b1, 133'hD, 12'h00D, 1'b1, 1'b1, 1'b1);
        step(1'b0, 133'h0, 12'h000, 1'b1, 1'b0, 1'b1);
        // Reset from TWO with flush and in_valid asserted.
        step(1'b1, 133'h33, 12'h033, 1'b0, 1'b0, 1'b1);
        step(1'b1, 133'h44, 12'h044, 1'b0, 1'b0, 1'b1);
        step(1'b1, 133'h55, 12'h055, 1'b1, 1'b1, 1'b0);
        step(1'b0, 133'h0, 12'h000, 1'b1, 1'b0, 1'b1);
        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rnd_data(), CW'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 79) != 0);
        end
`ifdef PIPE_STALL_CNT_EN
        // Long stall to exercise saturation.
        step(1'b0, 133'h0, 12'h000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 133'h77, 12'h077, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 70000; i++) step(1'b0, 133'h0, 12'h000, 1'b0, 1'b0, 1'b1);
        chk("stall_sat", 160'(stall_cnt), 160'(16'hFFFF));
`endif
        step(1'b0, 133'h0, 12'h000, 1'b1, 1'b0, 1'b1);
        @(negedge clkIn);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
